// File: rtl/hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : hit_detector
// Brief    : Light-gun hit detector. Counts lit pclk cycles over one sample
//            frame and pulses hit or miss. Optional macro HIT_SCORE_EN adds a
//            saturating running hit score.
// Revision : 1.0
// ============================================================================
module hit_detector #(
  parameter int HIT_THRESHOLD = 1024,
  parameter int CNT_WIDTH     = 20
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 vsync,
  input  logic                 blanking,
  input  logic                 sensor,
  output logic                 hit,
  output logic                 miss,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] light_cnt,
  output logic [7:0]           score
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIGN  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DECIDE = 2'd3;

  // 33-bit compare so any threshold above the counter range simply never hits.
  localparam logic [32:0]          C_THRESH  = 33'(HIT_THRESHOLD);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic                 sens_meta_q, sens_s_q;
  logic                 vsync_p_q, blanking_p_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 busy_q, busy_d;
  logic [CNT_WIDTH-1:0] light_cnt_q, light_cnt_d;
  logic                 vsync_fall, blank_rise, meets;

  assign vsync_fall = vsync_p_q & ~vsync;
  assign blank_rise = ~blanking_p_q & blanking;
  assign meets      = (33'(cnt_q) >= C_THRESH);

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (blank_rise) state_d = S_ALIGN;
      S_ALIGN:  if (vsync_fall) state_d = S_SAMPLE;
      S_SAMPLE: if (vsync_fall) state_d = S_DECIDE;
      S_DECIDE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    busy_d      = (state_q != S_IDLE);
    light_cnt_d = light_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (blank_rise) cnt_d = '0;
      end
      S_SAMPLE: begin
        if (sens_s_q && (cnt_q != C_CNT_MAX)) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      S_DECIDE: begin
        hit_d       = meets;
        miss_d      = ~meets;
        light_cnt_d = cnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      sens_meta_q  <= 1'b0;
      sens_s_q     <= 1'b0;
      vsync_p_q    <= 1'b0;
      blanking_p_q <= 1'b0;
      cnt_q        <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      busy_q       <= 1'b0;
      light_cnt_q  <= '0;
    end else begin
      sens_meta_q  <= sensor;
      sens_s_q     <= sens_meta_q;
      vsync_p_q    <= vsync;
      blanking_p_q <= blanking;
      cnt_q        <= cnt_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      busy_q       <= busy_d;
      light_cnt_q  <= light_cnt_d;
    end
  end

  assign hit       = hit_q;
  assign miss      = miss_q;
  assign busy      = busy_q;
  assign light_cnt = light_cnt_q;

`ifdef HIT_SCORE_EN
  logic [7:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (hit_d && (score_q != 8'hFF)) score_d = score_q + 8'd1;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      score_q <= 8'd0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule
`default_nettype wire
